// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues load/store transactions on a req/ack bus,
// aligns and extends load data, and stalls upstream while a transaction is open.
module mem_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ex_pc,
    input  logic [31:0]       ex_alu_out,
    input  logic [5:0]        ex_op,
    input  logic [4:0]        ex_rwa,
    input  logic              ex_mux_3,
    input  logic              ex_wce,
    input  logic [31:0]       ex_sdata,
    output logic [31:0]       mem_pc,
    output logic [31:0]       mem_alu_out,
    output logic [5:0]        mem_op,
    output logic [4:0]        mem_rwa,
    output logic              mem_mux_3,
    output logic              mem_wce,
    output logic              mem_stall,
    output logic [1:0]        mem_excp,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      ld_data_q;
    logic             bus_err_q;

    logic             is_load_s;
    logic             is_store_s;
    logic [1:0]       size_s;
    logic             access_s;
    logic             misaligned_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;

    // Select the addressed lane and sign/zero-extend according to the load opcode
    function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                               input logic [1:0]  a,
                                               input logic [5:0]  op);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            6'h20:   align_load = {{24{b[7]}}, b};
            6'h24:   align_load = {24'd0, b};
            6'h21:   align_load = {{16{h[15]}}, h};
            6'h25:   align_load = {16'd0, h};
            default: align_load = rdata;
        endcase
    endfunction

    // Opcode decode into access class and size
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        size_s     = SZ_WORD;
        case (ex_op)
            6'h20, 6'h24: begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            6'h21, 6'h25: begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            6'h23:        begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            6'h28:        begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            6'h29:        begin is_store_s = 1'b1; size_s = SZ_HALF; end
            6'h2B:        begin is_store_s = 1'b1; size_s = SZ_WORD; end
            default:      begin is_load_s  = 1'b0; is_store_s = 1'b0; end
        endcase
    end

    assign access_s     = is_load_s | is_store_s;
    assign misaligned_s = ((size_s == SZ_HALF) && ex_alu_out[0]) ||
                          ((size_s == SZ_WORD) && (ex_alu_out[1:0] != 2'b00));

    // Byte enables and lane-replicated store data
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = ex_sdata;
        case (size_s)
            SZ_BYTE: begin
                be_s    = 4'b0001 << ex_alu_out[1:0];
                wdata_s = {4{ex_sdata[7:0]}};
            end
            SZ_HALF: begin
                be_s    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{ex_sdata[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = ex_sdata;
            end
        endcase
    end

    // Transaction FSM; all bus outputs are registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ld_data_q  <= 32'd0;
            bus_err_q  <= 1'b0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= 4'd0;
            dbus_wdata <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bus_err_q <= 1'b0;
                    cnt_q     <= '0;
                    if (access_s && !misaligned_s) begin
                        state_q    <= S_REQ;
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store_s;
                        dbus_addr  <= {ex_alu_out[ADDR_W-1:2], 2'b00};
                        dbus_be    <= be_s;
                        dbus_wdata <= wdata_s;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (dbus_ack || (cnt_q == CNT_LAST)) begin
                        state_q    <= S_DONE;
                        ld_data_q  <= dbus_ack ? align_load(dbus_rdata, ex_alu_out[1:0], ex_op) : 32'd0;
                        bus_err_q  <= ~dbus_ack;
                        dbus_req   <= 1'b0;
                        dbus_we    <= 1'b0;
                        dbus_addr  <= '0;
                        dbus_be    <= 4'd0;
                        dbus_wdata <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output mux: pass-through, bubble while stalled, load result on completion
    always_comb begin
        mem_pc      = ex_pc;
        mem_alu_out = ex_alu_out;
        mem_op      = ex_op;
        mem_rwa     = ex_rwa;
        mem_mux_3   = ex_mux_3;
        mem_wce     = ex_wce;
        mem_stall   = 1'b0;
        mem_excp    = 2'b00;
        if (!rst_n) begin
            mem_wce = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access_s && misaligned_s) begin
                        mem_wce  = 1'b0;
                        mem_excp = 2'b01;
                    end else if (access_s) begin
                        mem_stall = 1'b1;
                        mem_wce   = 1'b0;
                        mem_op    = 6'd0;
                        mem_rwa   = 5'd0;
                        mem_mux_3 = 1'b0;
                    end else begin
                        mem_stall = 1'b0;
                    end
                end
                S_REQ: begin
                    mem_stall = 1'b1;
                    mem_wce   = 1'b0;
                    mem_op    = 6'd0;
                    mem_rwa   = 5'd0;
                    mem_mux_3 = 1'b0;
                end
                S_DONE: begin
                    mem_alu_out = is_load_s ? ld_data_q : ex_alu_out;
                    mem_wce     = ex_wce & ~bus_err_q;
                    mem_excp    = {bus_err_q, 1'b0};
                end
                default: begin
                    mem_stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed load/store/exception vectors,
// a driver that also plays the bus slave, and decoupled result/bus monitors.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ex_pc, ex_alu_out, ex_sdata;
    logic [5:0]  ex_op;
    logic [4:0]  ex_rwa;
    logic        ex_mux_3, ex_wce;
    logic [31:0] mem_pc, mem_alu_out;
    logic [5:0]  mem_op;
    logic [4:0]  mem_rwa;
    logic        mem_mux_3, mem_wce, mem_stall;
    logic [1:0]  mem_excp;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata, dbus_rdata;
    logic        dbus_ack;

    mem_stage #(.ADDR_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_pc(ex_pc), .ex_alu_out(ex_alu_out), .ex_op(ex_op), .ex_rwa(ex_rwa),
        .ex_mux_3(ex_mux_3), .ex_wce(ex_wce), .ex_sdata(ex_sdata),
        .mem_pc(mem_pc), .mem_alu_out(mem_alu_out), .mem_op(mem_op), .mem_rwa(mem_rwa),
        .mem_mux_3(mem_mux_3), .mem_wce(mem_wce), .mem_stall(mem_stall), .mem_excp(mem_excp),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_NOP = 6'h3F;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rwa;
        logic [31:0] alu;
        logic        wce;
        logic [1:0]  excp;
        int          stalls;
        bit          alu_dc;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    res_t res_q[$];
    bus_t bus_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   in_flight = 1'b0;
    int   stall_cnt = 0;
    int   instr_id = 0;
    bit   req_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Result monitor: bubbles while stalled, full compare when the stage retires
    always @(negedge clk) begin
        res_t e;
        if (in_flight && rst_n) begin
            if (mem_stall) begin
                stall_cnt++;
                check("bubble_wce", {31'd0, mem_wce}, 32'd0);
            end else begin
                if (res_q.size() == 0) begin
                    n_total++;
                    $display("FAIL retire: result with no expected entry");
                end else begin
                    e = res_q.pop_front();
                    check("pc", mem_pc, e.pc);
                    check("rwa", {27'd0, mem_rwa}, {27'd0, e.rwa});
                    if (!e.alu_dc) check("alu_out", mem_alu_out, e.alu);
                    check("wce", {31'd0, mem_wce}, {31'd0, e.wce});
                    check("excp", {30'd0, mem_excp}, {30'd0, e.excp});
                    if (e.stalls >= 0) check("stall_cycles", stall_cnt, e.stalls);
                end
                stall_cnt = 0;
            end
        end
    end

    // Bus monitor: compare each new request against the expected transaction
    always @(negedge clk) begin
        bus_t b;
        if (dbus_req && !req_seen) begin
            if (bus_q.size() == 0) begin
                n_total++;
                $display("FAIL bus_req: unexpected request addr 0x%08h", dbus_addr);
            end else begin
                b = bus_q.pop_front();
                check("bus_we", {31'd0, dbus_we}, {31'd0, b.we});
                check("bus_addr", dbus_addr, b.addr);
                check("bus_be", {28'd0, dbus_be}, {28'd0, b.be});
                if (b.we) check("bus_wdata", dbus_wdata, b.wdata);
            end
        end
        req_seen = dbus_req;
    end

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        bus_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    // Drive one instruction, answer its bus request after ack_lat req cycles (0 = never)
    task automatic run_instr(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                             input logic wce, input int ack_lat, input logic [31:0] rdata,
                             input logic [31:0] exp_alu, input logic exp_wce, input logic [1:0] exp_excp,
                             input int exp_stalls, input bit alu_dc);
        res_t e;
        int   k = 0;
        bit   acked = 1'b0;
        bit   done = 1'b0;
        instr_id++;
        e.pc = 32'h1000 + 32'(instr_id * 4); e.rwa = 5'(instr_id);
        e.alu = exp_alu; e.wce = exp_wce; e.excp = exp_excp; e.stalls = exp_stalls; e.alu_dc = alu_dc;
        res_q.push_back(e);
        @(posedge clk); #1;
        ex_pc = e.pc; ex_rwa = e.rwa; ex_op = op; ex_alu_out = addr; ex_sdata = sdata;
        ex_wce = wce; ex_mux_3 = (op[5:3] == 3'b100);
        in_flight = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (dbus_ack) dbus_ack = 1'b0;
            if (dbus_req && !acked) begin
                k++;
                if (k == ack_lat) begin
                    dbus_ack = 1'b1; dbus_rdata = rdata; acked = 1'b1;
                end
            end
            if (!mem_stall) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL wait_retire: op 0x%02h never released stall", op);
        end
        @(posedge clk); #1;
        in_flight = 1'b0; dbus_ack = 1'b0; ex_op = OP_NOP; ex_wce = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'd0;
        ex_pc = 32'h0; ex_alu_out = 32'h40; ex_op = 6'h23; ex_rwa = 5'd3;
        ex_mux_3 = 1'b1; ex_wce = 1'b1; ex_sdata = 32'h0;

        // Reset state with an aligned LW presented at the inputs
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, dbus_req}, 32'd0);
        check("rst_be", {28'd0, dbus_be}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_wce", {31'd0, mem_wce}, 32'd0);
        check("rst_excp", {30'd0, mem_excp}, 32'd0);
        check("rst_alu", mem_alu_out, 32'h40);
        @(posedge clk); #1;
        ex_op = OP_NOP; ex_wce = 1'b0; rst_n = 1'b1;

        run_instr(6'h00, 32'h1234, 32'h0, 1'b1, 0, 32'h0, 32'h1234, 1'b1, 2'b00, 0, 1'b0);

        push_bus(1'b0, 32'h100, 4'b1000, 32'h0);
        run_instr(6'h20, 32'h103, 32'h0, 1'b1, 1, 32'h80FF_1122, 32'hFFFF_FF80, 1'b1, 2'b00, 2, 1'b0);
        push_bus(1'b0, 32'h100, 4'b1100, 32'h0);
        run_instr(6'h25, 32'h102, 32'h0, 1'b1, 3, 32'h80FF_1122, 32'h0000_80FF, 1'b1, 2'b00, 4, 1'b0);
        push_bus(1'b0, 32'h100, 4'b1100, 32'h0);
        run_instr(6'h21, 32'h102, 32'h0, 1'b1, 1, 32'h80FF_1122, 32'hFFFF_80FF, 1'b1, 2'b00, 2, 1'b0);
        push_bus(1'b0, 32'h100, 4'b0010, 32'h0);
        run_instr(6'h24, 32'h101, 32'h0, 1'b1, 1, 32'h80FF_1122, 32'h0000_0011, 1'b1, 2'b00, 2, 1'b0);
        push_bus(1'b0, 32'h104, 4'b1111, 32'h0);
        run_instr(6'h23, 32'h104, 32'h0, 1'b1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 2'b00, 3, 1'b0);

        push_bus(1'b1, 32'h200, 4'b0010, 32'hDDDD_DDDD);
        run_instr(6'h28, 32'h201, 32'hAABB_CCDD, 1'b0, 2, 32'h0, 32'h201, 1'b0, 2'b00, 3, 1'b0);
        push_bus(1'b1, 32'h200, 4'b1100, 32'h5678_5678);
        run_instr(6'h29, 32'h202, 32'h1234_5678, 1'b0, 1, 32'h0, 32'h202, 1'b0, 2'b00, 2, 1'b0);
        push_bus(1'b1, 32'h300, 4'b1111, 32'hCAFE_F00D);
        run_instr(6'h2B, 32'h300, 32'hCAFE_F00D, 1'b0, 1, 32'h0, 32'h300, 1'b0, 2'b00, 2, 1'b0);

        // Misaligned accesses: no bus traffic, immediate exception
        run_instr(6'h23, 32'h106, 32'h0, 1'b1, 1, 32'h0, 32'h106, 1'b0, 2'b01, 0, 1'b0);
        run_instr(6'h21, 32'h101, 32'h0, 1'b1, 1, 32'h0, 32'h101, 1'b0, 2'b01, 0, 1'b0);

        // Bus timeout
        push_bus(1'b0, 32'h400, 4'b1111, 32'h0);
        run_instr(6'h23, 32'h400, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1'b0, 2'b10, -1, 1'b1);

        // Reset while a request is outstanding, then a late ack
        push_bus(1'b0, 32'h500, 4'b1111, 32'h0);
        @(posedge clk); #1;
        ex_op = 6'h23; ex_alu_out = 32'h500; ex_wce = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0; ex_op = OP_NOP;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstreq_req", {31'd0, dbus_req}, 32'd0);
        check("rstreq_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1 dbus_ack = 1'b1; dbus_rdata = 32'h1111_2222;
        @(negedge clk);
        check("late_ack_req", {31'd0, dbus_req}, 32'd0);
        check("late_ack_excp", {30'd0, mem_excp}, 32'd0);
        @(posedge clk); #1 dbus_ack = 1'b0;
        @(negedge clk);
        check("late_ack_stall", {31'd0, mem_stall}, 32'd0);
        check("late_ack_wce", {31'd0, mem_wce}, 32'd1);

        push_bus(1'b0, 32'h104, 4'b1111, 32'h0);
        run_instr(6'h23, 32'h104, 32'h0, 1'b1, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 2'b00, 2, 1'b0);

        repeat (2) @(posedge clk);
        check("res_q_empty", res_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline.
- Sits between the EX/MEM register and the MEM/WB register; its `mem_*` outputs feed MEM/WB directly.
- Issues load/store transactions on a req/ack data bus.
- Aligns and sign/zero-extends load data.
- Stalls the upstream pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width
- TIMEOUT, 255, ack-wait cycles before the bus-error abort

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ex_pc  in  32  PC of the instruction in MEM
- ex_alu_out  in  32  ALU result / effective address
- ex_op  in  6  opcode
- ex_rwa  in  5  destination register
- ex_mux_3  in  1  writeback selects memory data
- ex_wce  in  1  register write enable
- ex_sdata  in  32  store data (rt)
- mem_pc  out  32  to MEM/WB
- mem_alu_out  out  32  ALU result or load data
- mem_op  out  6  to MEM/WB
- mem_rwa  out  5  to MEM/WB
- mem_mux_3  out  1  to MEM/WB
- mem_wce  out  1  to MEM/WB
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_excp  out  2  {bus_err, misaligned}, 1-cycle pulse
- dbus_req  out  1  transaction request (registered)
- dbus_we  out  1  write
- dbus_addr  out  ADDR_W  word address, bits[1:0]=0
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_rdata  in  32  read data, valid with ack
- dbus_ack  in  1  transaction complete

Behaviour:
- Reset: FSM=IDLE.
  - All `dbus_*` outputs 0; `mem_excp`=0; `mem_stall`=0.
  - `mem_*` pass-through of `ex_*`, with `mem_wce`=0 during the reset cycle.
- Access ops:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - All other ops are non-access.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
- IDLE, non-access op: combinational pass-through, zero latency, `mem_stall`=0.
- IDLE, misaligned access:
  - No bus transaction; `mem_excp[0]`=1 for that cycle.
  - Outputs pass through with `mem_wce`=0; stay IDLE.
- IDLE, aligned access:
  - `mem_stall`=1 combinationally; outputs bubble (`mem_wce`=0, `mem_op`=0, `mem_rwa`=0, `mem_mux_3`=0).
  - Next edge: register `dbus_req`=1, addr, we, be, wdata; go REQ.
- Byte enables:
  - Byte: `be` = 1<<addr[1:0].
  - Half: 4'b0011 if addr[1]=0, else 4'b1100.
  - Word: 4'b1111.
  - Loads and stores use the same `be`.
- Store data: SB replicates byte×4; SH replicates half×2; SW raw.
- REQ:
  - `dbus_*` held stable; `mem_stall`=1; bubble outputs; wait counter increments.
  - On `dbus_ack`:
    - Capture the aligned/extended load result into `ld_data`.
    - Drop `dbus_req` next edge; go DONE.
  - Counter reaches TIMEOUT with no ack:
    - Drop req; `mem_excp[1]`=1 for one cycle in DONE.
    - Go DONE with `mem_wce` forced 0.
- Load extension:
  - Select lane by addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend.
- DONE (exactly 1 cycle):
  - `mem_stall`=0; outputs from `ex_*` (held stable by the stall).
  - Loads: `mem_alu_out`=`ld_data`. Stores: `mem_alu_out`=`ex_alu_out`.
  - Next: IDLE.
- Latency: access detected at cycle T; req high T+1..T+n (ack at T+n, n≥1); result on outputs at T+n+1.
  - Zero-wait ack gives 2 stall cycles.
- Boundaries:
  - Ack in IDLE or DONE is ignored.
  - Upstream must hold `ex_*` stable while `mem_stall`=1; the block does not re-sample them.
  - Back-to-back access ops: DONE→IDLE then a new detect; no overlap.
  - Reset mid-REQ: `dbus_req` drops at that edge; a late ack is ignored.

Test Plan:
- ADDU-type op 0x00, `ex_alu_out`=0x1234, `ex_wce`=1 → same-cycle `mem_alu_out`=0x1234, `mem_wce`=1, `mem_stall`=0, `dbus_req`=0.
- LB @0x103, memory word 0x80FF_1122, ack 1 cycle after req:
  - Expect `be`=4'b1000, `dbus_addr`=0x100.
  - Expect 2 stall cycles, then `mem_alu_out`=0xFFFF_FF80, `mem_wce`=1.
- LHU @0x102 on the same word, ack delayed 3 cycles:
  - Expect `be`=4'b1100.
  - Expect 4 stall cycles, then `mem_alu_out`=0x0000_80FF.
- SB @0x201, rt=0xAABB_CCDD:
  - Expect `dbus_we`=1, `be`=4'b0010, `wdata`=0xDDDD_DDDD.
  - Expect req held until ack, then `mem_wce`=0 passed from `ex_wce`.
- LW @0x106 (misaligned) → `mem_excp`=2'b01 for 1 cycle, no `dbus_req`, `mem_wce`=0, no stall.
- Two stimuli, run separately:
  - LW with no ack for TIMEOUT cycles → `mem_excp`=2'b10, `mem_wce`=0.
  - LW with `rst_n` low mid-REQ → `dbus_req`=0 and FSM IDLE next cycle; later ack ignored.
